// File: rtl/wb_request_issuer.sv
// wb_request_issuer
// Buffers cache evictions (addr+data) in a DEPTH-entry FIFO and issues them
// one at a time to the downstream processor over a four-phase memwr/ack
// handshake (IDLE -> REQ -> REL -> IDLE).
// Optional build macro: WB_COALESCE_EN -- an accepted eviction whose address
// matches a queued, not-in-flight entry overwrites that entry's data instead
// of allocating a new slot.
module wb_request_issuer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              evict_valid,
    input  logic [ADDR_W-1:0] evict_addr,
    input  logic [DATA_W-1:0] evict_data,
    output logic              evict_ready,
    output logic              memwr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              ack,
    output logic              busy,
    output logic [PW:0]       count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push;
    logic              push_new;
    logic              pop;
    logic              launch;
    logic              hit;

    // Readiness comes straight from the registered count.
    assign evict_ready = (count != CNT_FULL);
    assign push        = evict_valid && evict_ready;
    assign push_new    = push && !hit;
    assign busy        = (state != IDLE) || (count != '0);

`ifdef WB_COALESCE_EN
    logic [PW-1:0] hit_idx;

    // Find a queued entry with the same address; the head is excluded once it
    // is in flight or being launched on this edge, so its issued data never changes.
    always_comb begin
        logic [PW-1:0] off;
        logic          head_locked;
        hit         = 1'b0;
        hit_idx     = '0;
        off         = '0;
        head_locked = (state != IDLE) || launch;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (!hit && ({1'b0, off} < count) && !(off == '0 && head_locked)
                && (fifo_addr[i] == evict_addr)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Handshake next-state decode; launch loads the head, pop retires it.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0 && !ack) begin
                    launch     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    state_next = REL;
                end
            end
            REL: begin
                if (!ack) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO storage: new entries at the tail, coalesced data in place.
    always_ff @(posedge clk) begin
        if (push_new) begin
            fifo_addr[wr_ptr] <= evict_addr;
            fifo_data[wr_ptr] <= evict_data;
        end
`ifdef WB_COALESCE_EN
        else if (push && hit) begin
            fifo_data[hit_idx] <= evict_data;
        end
`endif
    end

    // State, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            if (push_new) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_new, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Registered request outputs; address/data hold their last value after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memwr    <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            memwr <= (state_next == REQ);
            if (launch) begin
                mem_addr <= fifo_addr[rd_ptr];
                mem_data <= fifo_data[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_wb_request_issuer.sv
// Testbench for wb_request_issuer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model with a decoupled write monitor.
module tb_wb_request_issuer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int PW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              evict_valid = 1'b0;
    logic [ADDR_W-1:0] evict_addr = '0;
    logic [DATA_W-1:0] evict_data = '0;
    logic              evict_ready;
    logic              memwr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              ack = 1'b0;
    logic              busy;
    logic [PW:0]       count;

    wb_request_issuer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
        .evict_ready(evict_ready),
        .memwr(memwr), .mem_addr(mem_addr), .mem_data(mem_data),
        .ack(ack), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    // Reference model: writes not yet issued, in issue order.
    ent_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   mcount = 0;     // entries the DUT should hold (incl. in-flight head)
    int   hs     = 0;     // downstream agent: 0 idle, 1 req seen, 2 acked, 3 released
    int   mode   = 0;     // 0 random ack, 1 hold ack low, 2 hold ack high (stale)
    bit   exp_launch = 1'b0;
    logic memwr_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every new write request must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && memwr && !memwr_prev) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: actual addr=%0h data=%0h, required none", mem_addr, mem_data);
            end else begin
                ent_t e;
                e = expq.pop_front();
                chk("mem_addr", mem_addr, e.a);
                chk("mem_data", mem_data, e.d);
            end
        end
        memwr_prev = memwr;
    end

    // One clock of stimulus: check state, act as downstream agent, drive an eviction.
    task automatic step(input bit v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit launch_now;
        bit acc;
        bit hit;
        bit popnow;
        @(negedge clk);
        #1;
        chk("count", count, mcount);
        chk("evict_ready", evict_ready, mcount != DEPTH);
        chk("busy", busy, mcount != 0);
        case (hs)
            0: begin
                chk("memwr_launch", memwr, exp_launch);
                if (memwr) hs = 1;
            end
            1: chk("memwr_held", memwr, 1);
            2: chk("memwr_released", memwr, 0);
            default: begin
                chk("memwr_after_pop", memwr, 0);
                hs = 0;
            end
        endcase
        popnow = 1'b0;
        if (hs == 0) begin
            ack = (mode == 2);
        end else if (hs == 1) begin
            if (mode == 0 && $urandom_range(0, 2) == 0) begin
                ack = 1'b1;
                hs  = 2;
            end
        end else if (hs == 2) begin
            if (mode == 0 && $urandom_range(0, 2) == 0) begin
                ack    = 1'b0;
                hs     = 3;
                popnow = 1'b1;
            end
        end
        launch_now  = (hs == 0) && !ack && (mcount != 0);
        evict_valid = v;
        evict_addr  = a;
        evict_data  = d;
        acc = v && (mcount != DEPTH);
        hit = 1'b0;
        if (acc) begin
`ifdef WB_COALESCE_EN
            for (int i = (launch_now ? 1 : 0); i < expq.size(); i++) begin
                if (!hit && expq[i].a == a) begin
                    expq[i].d = d;
                    hit = 1'b1;
                end
            end
`endif
            if (!hit) expq.push_back('{a: a, d: d});
        end
        mcount = mcount + ((acc && !hit) ? 1 : 0) - (popnow ? 1 : 0);
        exp_launch = launch_now;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        mode = 0;
        while ((mcount != 0 || hs != 0) && n < budget) begin
            step(1'b0, '0, '0);
            n++;
        end
        chk({name, "_timeout"}, mcount, 0);
        idle_steps(2);
        chk({name, "_queue_empty"}, expq.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ack = 1'b0;
        evict_valid = 1'b0;
        expq.delete();
        mcount = 0;
        hs = 0;
        exp_launch = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        // Reset values
        #1;
        chk("rst_memwr", memwr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_evict_ready", evict_ready, 1);
        do_reset();

        // Single write: memwr one edge after the push, then full handshake
        mode = 1;
        step(1'b1, 32'h10, 32'hAA);
        idle_steps(2);
        drain("single", 50);

        // Fill to DEPTH; a fifth eviction is dropped
        do_reset();
        mode = 1;
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h50 + 32'(i), 32'h500 + 32'(i));
        step(1'b1, 32'h99, 32'h999);
        idle_steps(2);
        chk("full_count", count, DEPTH);
        mode = 0;
        n = 0;
        while (mcount == DEPTH && n < 50) begin
            step(1'b0, '0, '0);
            n++;
        end
        step(1'b0, '0, '0);
        chk("ready_after_pop", evict_ready, 1);
        drain("full", 100);

        // Stale ack before the first push holds off the request
        do_reset();
        mode = 2;
        step(1'b0, '0, '0);
        step(1'b1, 32'h40, 32'h44);
        idle_steps(4);
        chk("stale_no_req", memwr, 0);
        mode = 0;
        drain("stale", 50);

        // Reset during REQ with three entries queued
        do_reset();
        mode = 1;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h60 + 32'(i), 32'h600 + 32'(i));
        idle_steps(1);
        @(posedge clk);
        #2;
        chk("pre_reset_memwr", memwr, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_memwr", memwr, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_busy", busy, 0);
        do_reset();
        mode = 0;
        idle_steps(8);

        // Address coalescing scenario (same stimulus in both builds)
        do_reset();
        mode = 1;
        step(1'b1, 32'h20, 32'h1);
        idle_steps(2);
        step(1'b1, 32'h30, 32'h2);
        step(1'b1, 32'h30, 32'h9);
        step(1'b1, 32'h20, 32'h5);
        idle_steps(1);
`ifdef WB_COALESCE_EN
        chk("coalesce_count", count, 3);
`else
        chk("coalesce_count", count, 4);
`endif
        drain("coalesce", 100);

        // Randomized traffic over a small address set
        do_reset();
        mode = 0;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 6, 32'h100 + 32'($urandom_range(0, 5)), $urandom);
        end
        drain("random", 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
